framebuffer_scanout: RTL and testbench
======================================

// Module: framebuffer_scanout
// PURPOSE
// - Receiving end of the sprite/background drawer pixel-write interface (plot, x, y, colour).
// - Stores 320x240 3-bit pixels in a dual-port frame buffer; scans it out as 640x480@60 VGA, each pixel doubled in x and y.
// - Sits between the sprite FSM/drawer and the board VGA DAC. It replaces the vendor VGA adapter.
// PARAMETERS
// - FB_W       320  frame buffer width in pixels
// - FB_H       240  frame buffer height in pixels
// - H_VIS 640, H_FP 16, H_SYNC 96, H_BP 48   horizontal timing in pixel ticks (total 800)
// - V_VIS 480, V_FP 10, V_SYNC 2,  V_BP 33   vertical timing in lines (total 525)
// PORTS
// - clock      in   1   50 MHz system clock
// - reset      in   1   asynchronous, active-high reset
// - plot       in   1   write strobe; one pixel written per cycle it is high
// - x          in   9   write column, 0..319
// - y          in   8   write row, 0..239
// - colour     in   3   {R,G,B} write data
// - vga_clk    out  1   25 MHz pixel clock = registered clock/2
// - vga_hs     out  1   horizontal sync, active low
// - vga_vs     out  1   vertical sync, active low
// - vga_blank_n out 1   high in the visible region
// - vga_sync_n out  1   tied 0
// - vga_r/g/b  out  8   each output is its colour bit replicated 8x; 0 when blanked
// - frame_start out 1   one-clock pulse at the pixel tick where h=0, v=0
// BEHAVIOUR
// - Reset values: pix_en=0, hcount=0, vcount=0, all outputs 0. vga_hs and vga_vs reset to 1 (inactive).
//   The RAM contents are not reset.
// - Pixel tick: pix_en toggles every clock. The counters and the output pipeline advance only on cycles with pix_en=1.
//   vga_clk = ~pix_en, registered, so the DAC samples mid-period.
// - hcount wraps 799->0. vcount increments on the hcount wrap and wraps 524->0.
// - Sync timing:
//   - hs low for hcount in 656..751.
//   - vs low for vcount in 490..491.
//   - visible region: hcount<640 && vcount<480.
// - Write port:
//   - When plot=1 and x<FB_W and y<FB_H, mem[y*320+x] <= colour on that clock edge.
//   - Out-of-range writes are silently dropped.
//   - Writes are accepted on every clock, regardless of pix_en. There is no back-pressure and no busy signal.
// - Address: 17 bits, computed as (y<<8)+(y<<6)+x. No multiplier.
// - Read port:
//   - Read address = (vcount>>1)*320 + (hcount>>1), registered at pipeline stage 1.
//   - RAM data is valid at stage 2. RGB, hs, vs and blank are registered at stage 2.
//   - All outputs therefore lag the counter position by exactly 2 pixel ticks and stay mutually aligned.
// - Collision: a write and a read to the same address in the same clock return the old data (read-before-write).
//   The new value appears on the next frame.
// - A write during active scanout is legal. Tearing is acceptable.
// - A reset asserted mid-frame:
//   - forces the counters and outputs to their reset values immediately (async);
//   - restarts a frame from h=0, v=0 on release;
//   - leaves the RAM untouched.
// - frame_start is asserted at the counter stage (before the pipeline delay). It lets the drawers sync their updates.
// STRUCTURE
// - Shared package vga_pkg: timing localparams, FB_W/FB_H, address width (17), colour codes
//   (BLACK=3'b000, BG_TEAL=3'b011, CHAR_RED=3'b100).
// - Sub-module fb_dual_port_ram: 76800x3 simple dual-port memory, 1 write port and 1 registered read port,
//   read-before-write, inferable as block RAM.
// - Top level: pix_en toggle, h/v counters, address arithmetic, 2-stage output pipeline.
// TESTING
// - Reset, then 800x525 ticks -> hs low for exactly 96 ticks per line. vs low for exactly 2 lines per frame.
//   frame_start asserted once every 840000 clocks.
// - plot x=5 y=16 colour=3'b100 -> at display (h=10..11, v=32..33): vga_r=8'hFF, vga_g=0, vga_b=0. Neighbouring pixels unchanged.
// - plot x=320 y=0 and x=0 y=240 with colour 3'b111 -> no RAM change. Address 0 and the row-0 pixels keep their prior colour.
// - Write address A with 3'b010 in the same clock that the scanout reads A -> old colour shown this frame, 3'b010 on the next frame.
// - Assert reset at h=300, v=200 for 3 clocks -> all outputs 0, hs/vs 1. After release the first frame_start occurs
//   within 2 clocks. The pixel at x=5, y=16 still reads 3'b100.
// - Blanking: h=640..799 or v=480..524 -> vga_blank_n=0 and rgb=0, even when the RAM holds 3'b111.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the frame buffer scanout: VGA timing, frame buffer geometry,
// the colour codes used by the drawers, and the shift-and-add pixel address helper.
package vga_pkg;

   localparam logic [8:0] FB_W     = 9'd320;
   localparam logic [7:0] FB_H     = 8'd240;
   localparam int         FB_DEPTH = 76800;
   localparam int         ADDR_W   = 17;
   localparam int         COLOUR_W = 3;

   localparam logic [9:0] H_VIS  = 10'd640;
   localparam logic [9:0] H_FP   = 10'd16;
   localparam logic [9:0] H_SYNC = 10'd96;
   localparam logic [9:0] H_BP   = 10'd48;
   localparam logic [9:0] V_VIS  = 10'd480;
   localparam logic [9:0] V_FP   = 10'd10;
   localparam logic [9:0] V_SYNC = 10'd2;
   localparam logic [9:0] V_BP   = 10'd33;

   typedef enum logic [2:0] {
      BLACK    = 3'b000,
      BG_TEAL  = 3'b011,
      CHAR_RED = 3'b100
   } colour_e;

   // y*320 + x as (y<<8) + (y<<6) + x, so no multiplier is inferred
   function automatic logic [ADDR_W-1:0] fb_addr(input logic [8:0] px, input logic [7:0] py);
      return {1'b0, py, 8'h00} + {3'b000, py, 6'b000000} + {8'h00, px};
   endfunction

endpackage

// File: rtl/fb_dual_port_ram.sv
// 76800 x 3 simple dual-port frame buffer: one write port and one registered read port,
// read-before-write on a same-address collision. No reset so it maps onto block RAM.
module fb_dual_port_ram
   import vga_pkg::*;
(
   input  logic                clk,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [COLOUR_W-1:0] wr_data,
   input  logic                rd_en,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [COLOUR_W-1:0] rd_data
);

   logic [COLOUR_W-1:0] mem_q [0:FB_DEPTH-1];
   logic [COLOUR_W-1:0] rd_data_q;

   // The read samples the array before this edge's write lands, giving the old data
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/framebuffer_scanout.sv
// Drawer-facing pixel write port plus 640x480@60 VGA scanout of a 320x240 3-bit frame buffer,
// each stored pixel doubled in x and y. Outputs trail the counters by two pixel ticks.
module framebuffer_scanout
   import vga_pkg::*;
#(
   parameter logic [9:0] H_VISIBLE = H_VIS,
   parameter logic [9:0] H_FRONT   = H_FP,
   parameter logic [9:0] H_SYNC_W  = H_SYNC,
   parameter logic [9:0] H_BACK    = H_BP,
   parameter logic [9:0] V_VISIBLE = V_VIS,
   parameter logic [9:0] V_FRONT   = V_FP,
   parameter logic [9:0] V_SYNC_W  = V_SYNC,
   parameter logic [9:0] V_BACK    = V_BP
)(
   input  logic       clock,
   input  logic       reset,
   input  logic       plot,
   input  logic [8:0] x,
   input  logic [7:0] y,
   input  logic [2:0] colour,
   output logic       vga_clk,
   output logic       vga_hs,
   output logic       vga_vs,
   output logic       vga_blank_n,
   output logic       vga_sync_n,
   output logic [7:0] vga_r,
   output logic [7:0] vga_g,
   output logic [7:0] vga_b,
   output logic       frame_start
);

   localparam logic [9:0] H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC_W + H_BACK;
   localparam logic [9:0] V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC_W + V_BACK;
   localparam logic [9:0] HS_START = H_VISIBLE + H_FRONT;
   localparam logic [9:0] HS_END   = HS_START + H_SYNC_W;
   localparam logic [9:0] VS_START = V_VISIBLE + V_FRONT;
   localparam logic [9:0] VS_END   = VS_START + V_SYNC_W;

   logic                pix_en_q, pix_en_d;
   logic                vga_clk_q, vga_clk_d;
   logic [9:0]          hcount_q, hcount_d;
   logic [9:0]          vcount_q, vcount_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic                vis1_q, vis1_d, hs1_q, hs1_d, vs1_q, vs1_d;
   logic [COLOUR_W-1:0] rgb_q, rgb_d;
   logic                hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
   logic                frame_start_q, frame_start_d;
   logic                visible_s, hs_s, vs_s, wr_en_s;
   logic [ADDR_W-1:0]   rd_addr_s, wr_addr_s;
   logic [COLOUR_W-1:0] rd_data_s;

   // Next-state for the tick toggle, counters and both pipeline stages
   always_comb begin
      pix_en_d      = ~pix_en_q;
      vga_clk_d     = ~pix_en_q;
      hcount_d      = hcount_q;
      vcount_d      = vcount_q;
      rd_addr_d     = rd_addr_q;
      vis1_d        = vis1_q;
      hs1_d         = hs1_q;
      vs1_d         = vs1_q;
      rgb_d         = rgb_q;
      hs_d          = hs_q;
      vs_d          = vs_q;
      blank_n_d     = blank_n_q;
      frame_start_d = pix_en_q && (hcount_q == 10'd0) && (vcount_q == 10'd0);

      visible_s = (hcount_q < H_VISIBLE) && (vcount_q < V_VISIBLE);
      hs_s      = ~((hcount_q >= HS_START) && (hcount_q < HS_END));
      vs_s      = ~((vcount_q >= VS_START) && (vcount_q < VS_END));
      // Blanked positions read address 0 so the RAM is never indexed past its end
      if (visible_s) begin
         rd_addr_s = fb_addr(hcount_q[9:1], vcount_q[8:1]);
      end else begin
         rd_addr_s = 17'd0;
      end

      if (pix_en_q) begin
         if (hcount_q == H_TOTAL - 10'd1) begin
            hcount_d = 10'd0;
            if (vcount_q == V_TOTAL - 10'd1) begin
               vcount_d = 10'd0;
            end else begin
               vcount_d = vcount_q + 10'd1;
            end
         end else begin
            hcount_d = hcount_q + 10'd1;
         end
         rd_addr_d = rd_addr_s;
         vis1_d    = visible_s;
         hs1_d     = hs_s;
         vs1_d     = vs_s;
         if (vis1_q) begin
            rgb_d = rd_data_s;
         end else begin
            rgb_d = 3'b000;
         end
         hs_d      = hs1_q;
         vs_d      = vs1_q;
         blank_n_d = vis1_q;
      end else begin
         hcount_d = hcount_q;
         vcount_d = vcount_q;
      end
   end

   // Drawer writes are accepted on any clock; out-of-range coordinates are dropped
   always_comb begin
      wr_en_s   = plot && (x < FB_W) && (y < FB_H);
      wr_addr_s = fb_addr(x, y);
   end

   // State and output registers; syncs idle high in reset
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pix_en_q      <= 1'b0;
         vga_clk_q     <= 1'b0;
         hcount_q      <= 10'd0;
         vcount_q      <= 10'd0;
         rd_addr_q     <= 17'd0;
         vis1_q        <= 1'b0;
         hs1_q         <= 1'b1;
         vs1_q         <= 1'b1;
         rgb_q         <= 3'b000;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         blank_n_q     <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         pix_en_q      <= pix_en_d;
         vga_clk_q     <= vga_clk_d;
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         rd_addr_q     <= rd_addr_d;
         vis1_q        <= vis1_d;
         hs1_q         <= hs1_d;
         vs1_q         <= vs1_d;
         rgb_q         <= rgb_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         blank_n_q     <= blank_n_d;
         frame_start_q <= frame_start_d;
      end
   end

   // RAM reads on the clock after each tick, once the stage-1 address has settled
   fb_dual_port_ram u_ram (
      .clk     (clock),
      .wr_en   (wr_en_s),
      .wr_addr (wr_addr_s),
      .wr_data (colour),
      .rd_en   (~pix_en_q),
      .rd_addr (rd_addr_q),
      .rd_data (rd_data_s)
   );

   assign vga_clk     = vga_clk_q;
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign vga_blank_n = blank_n_q;
   assign vga_sync_n  = 1'b0;
   assign vga_r       = {8{rgb_q[2]}};
   assign vga_g       = {8{rgb_q[1]}};
   assign vga_b       = {8{rgb_q[0]}};
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed bench for framebuffer_scanout, run with a shrunken 56x48-tick raster so several
// frames fit in a short run; the frame buffer geometry and addressing stay full size.
module tb_framebuffer_scanout;
   import vga_pkg::*;

   localparam int HT    = 56;
   localparam int VT    = 48;
   localparam int FRAME = 2 * HT * VT;

   logic       clock = 1'b0;
   logic       reset;
   logic       plot;
   logic [8:0] x;
   logic [7:0] y;
   logic [2:0] colour;
   logic       vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start;
   logic [7:0] vga_r, vga_g, vga_b;

   int total = 0;
   int bad   = 0;
   int pos_cnt = 0;

   framebuffer_scanout #(
      .H_VISIBLE(10'd40), .H_FRONT(10'd4), .H_SYNC_W(10'd6), .H_BACK(10'd6),
      .V_VISIBLE(10'd40), .V_FRONT(10'd2), .V_SYNC_W(10'd2), .V_BACK(10'd4)
   ) dut (
      .clock(clock), .reset(reset), .plot(plot), .x(x), .y(y), .colour(colour),
      .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
      .vga_sync_n(vga_sync_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .frame_start(frame_start)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   // clocks after the frame_start cycle at which the output for raster position (h,v) is shown
   function automatic int samp(input int h, input int v);
      return 2 + 2 * (v * HT + h);
   endfunction

   task automatic adv(input int n);
      if (n > pos_cnt) begin
         repeat (n - pos_cnt) @(posedge clock);
         pos_cnt = n;
         @(negedge clock);
      end
   endtask

   task automatic sync_frame();
      int n = 0;
      @(negedge clock);
      while (frame_start !== 1'b1 && n < FRAME + 100) begin
         @(negedge clock);
         n++;
      end
      total++;
      if (frame_start !== 1'b1) begin
         $display("FAIL sync_frame: frame_start=%b after %0d clocks, required 1", frame_start, n);
         bad++;
      end
      pos_cnt = 0;
   endtask

   task automatic put(input logic [8:0] px, input logic [7:0] py, input logic [2:0] pc);
      @(negedge clock);
      plot = 1'b1; x = px; y = py; colour = pc;
      @(negedge clock);
      plot = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; plot = 1'b0; x = 9'd0; y = 8'd0; colour = 3'b000;
      repeat (3) @(negedge clock);
      total++;
      if ({vga_r, vga_g, vga_b} !== 24'h000000 || vga_blank_n !== 1'b0) begin
         $display("FAIL reset_rgb: rgb=%h blank_n=%b, required 000000/0", {vga_r, vga_g, vga_b}, vga_blank_n);
         bad++;
      end
      total++;
      if (vga_hs !== 1'b1 || vga_vs !== 1'b1) begin
         $display("FAIL reset_sync: hs=%b vs=%b, required 1/1", vga_hs, vga_vs);
         bad++;
      end
      total++;
      if (vga_clk !== 1'b0 || frame_start !== 1'b0 || vga_sync_n !== 1'b0) begin
         $display("FAIL reset_misc: vga_clk=%b frame_start=%b sync_n=%b, required 0/0/0",
                  vga_clk, frame_start, vga_sync_n);
         bad++;
      end
      reset = 1'b0;
   endtask

   task automatic fill_memory();
      for (int yy = 0; yy < 20; yy++)
         for (int xx = 0; xx < 20; xx++)
            put(9'(xx), 8'(yy), BG_TEAL);
      for (int xx = 20; xx < 28; xx++) put(9'(xx), 8'd0, 3'b111);
      for (int yy = 20; yy < 24; yy++)
         for (int xx = 0; xx < 20; xx++)
            put(9'(xx), 8'(yy), 3'b111);
   endtask

   task automatic test_frame_timing();
      int fs_n = 0, hs_tot = 0, vs_tot = 0, bl_tot = 0, line_hs = 0, bad_lines = 0, clk_err = 0;
      logic prev_clk;
      sync_frame();
      total++;
      if (vga_clk !== 1'b0) begin
         $display("FAIL vga_clk_phase: vga_clk=%b in frame_start cycle, required 0", vga_clk);
         bad++;
      end
      prev_clk = vga_clk;
      for (int c = 1; c <= FRAME; c++) begin
         @(posedge clock);
         @(negedge clock);
         if (vga_clk === prev_clk) clk_err++;
         prev_clk = vga_clk;
         if (vga_hs === 1'b0) begin hs_tot++; line_hs++; end
         if (vga_vs === 1'b0) vs_tot++;
         if (vga_blank_n === 1'b1) bl_tot++;
         if (frame_start === 1'b1) fs_n++;
         if (c % (2 * HT) == 0) begin
            if (line_hs != 12) bad_lines++;
            line_hs = 0;
         end
      end
      total++;
      if (fs_n != 1 || frame_start !== 1'b1) begin
         $display("FAIL frame_period: %0d pulses, last=%b over %0d clocks, required 1 pulse at the end",
                  fs_n, frame_start, FRAME);
         bad++;
      end
      total++;
      if (hs_tot != 576 || bad_lines != 0) begin
         $display("FAIL hs_width: hs low %0d clocks, %0d bad lines, required 576 and 0", hs_tot, bad_lines);
         bad++;
      end
      total++;
      if (vs_tot != 224) begin
         $display("FAIL vs_width: vs low %0d clocks, required 224", vs_tot);
         bad++;
      end
      total++;
      if (bl_tot != 3200) begin
         $display("FAIL visible_count: blank_n high %0d clocks, required 3200", bl_tot);
         bad++;
      end
      total++;
      if (clk_err != 0) begin
         $display("FAIL vga_clk_toggle: %0d clocks without toggle, required 0", clk_err);
         bad++;
      end
   endtask

   task automatic test_plot_and_oob();
      int hh [11];
      int vv [11];
      logic [23:0] ex [11];
      put(9'd5, 8'd16, CHAR_RED);
      put(9'd320, 8'd0, 3'b111);
      put(9'd0, 8'd240, 3'b111);
      hh = '{0, 38, 0, 10, 9, 10, 11, 12, 10, 11, 10};
      vv = '{0, 0, 2, 31, 32, 32, 32, 32, 33, 33, 34};
      ex = '{24'h00FFFF, 24'h00FFFF, 24'h00FFFF, 24'h00FFFF, 24'h00FFFF, 24'hFF0000,
             24'hFF0000, 24'h00FFFF, 24'hFF0000, 24'hFF0000, 24'h00FFFF};
      sync_frame();
      for (int i = 0; i < 11; i++) begin
         adv(samp(hh[i], vv[i]));
         total++;
         if ({vga_r, vga_g, vga_b} !== ex[i]) begin
            $display("FAIL plot_pixel h=%0d v=%0d: rgb=%h, required %h", hh[i], vv[i], {vga_r, vga_g, vga_b}, ex[i]);
            bad++;
         end
      end
   endtask

   task automatic test_collision();
      int p = 4 * HT + 6;
      sync_frame();
      adv(2 * p);
      plot = 1'b1; x = 9'd3; y = 8'd2; colour = 3'b010;
      @(posedge clock);
      pos_cnt++;
      @(negedge clock);
      plot = 1'b0;
      adv(samp(6, 4));
      total++;
      if ({vga_r, vga_g, vga_b} !== 24'h00FFFF) begin
         $display("FAIL collision_old: rgb=%h, required 00ffff", {vga_r, vga_g, vga_b});
         bad++;
      end
      sync_frame();
      adv(samp(6, 4));
      total++;
      if ({vga_r, vga_g, vga_b} !== 24'h00FF00) begin
         $display("FAIL collision_new: rgb=%h, required 00ff00", {vga_r, vga_g, vga_b});
         bad++;
      end
   endtask

   task automatic test_reset_mid_frame();
      int n = 0;
      sync_frame();
      adv(2 * (20 * HT + 30));
      reset = 1'b1;
      #1;
      total++;
      if ({vga_r, vga_g, vga_b} !== 24'h000000 || vga_blank_n !== 1'b0 || vga_hs !== 1'b1 ||
          vga_vs !== 1'b1 || frame_start !== 1'b0 || vga_clk !== 1'b0) begin
         $display("FAIL reset_async: rgb=%h blank_n=%b hs=%b vs=%b fs=%b clk=%b, required 000000/0/1/1/0/0",
                  {vga_r, vga_g, vga_b}, vga_blank_n, vga_hs, vga_vs, frame_start, vga_clk);
         bad++;
      end
      repeat (3) @(posedge clock);
      @(negedge clock);
      total++;
      if (vga_hs !== 1'b1 || vga_vs !== 1'b1 || vga_blank_n !== 1'b0) begin
         $display("FAIL reset_hold: hs=%b vs=%b blank_n=%b, required 1/1/0", vga_hs, vga_vs, vga_blank_n);
         bad++;
      end
      reset = 1'b0;
      while (frame_start !== 1'b1 && n < 10) begin
         @(negedge clock);
         n++;
      end
      total++;
      if (frame_start !== 1'b1 || n > 2) begin
         $display("FAIL reset_restart: frame_start after %0d clocks, required within 2", n);
         bad++;
      end
      pos_cnt = 0;
      adv(samp(10, 32));
      total++;
      if ({vga_r, vga_g, vga_b} !== 24'hFF0000) begin
         $display("FAIL reset_ram_kept: rgb=%h, required ff0000", {vga_r, vga_g, vga_b});
         bad++;
      end
   endtask

   task automatic test_blanking();
      int hh [9];
      int vv [9];
      logic [23:0] ex [9];
      logic [2:0] ctl [9];
      put(9'd19, 8'd0, 3'b111);
      // ctl = {blank_n, hs, vs}
      hh  = '{38, 40, 43, 44, 49, 50, 10, 10, 10};
      vv  = '{0, 0, 0, 0, 0, 0, 41, 42, 44};
      ex  = '{24'hFFFFFF, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
      ctl = '{3'b111, 3'b011, 3'b011, 3'b001, 3'b001, 3'b011, 3'b011, 3'b010, 3'b011};
      sync_frame();
      for (int i = 0; i < 9; i++) begin
         adv(samp(hh[i], vv[i]));
         total++;
         if ({vga_r, vga_g, vga_b} !== ex[i] || {vga_blank_n, vga_hs, vga_vs} !== ctl[i]) begin
            $display("FAIL blanking h=%0d v=%0d: rgb=%h blank_n/hs/vs=%b, required %h %b",
                     hh[i], vv[i], {vga_r, vga_g, vga_b}, {vga_blank_n, vga_hs, vga_vs}, ex[i], ctl[i]);
            bad++;
         end
      end
   endtask

   initial begin
      test_reset();
      fill_memory();
      test_frame_timing();
      test_plot_and_oob();
      test_collision();
      test_reset_mid_frame();
      test_blanking();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
